// File: rtl/reg_alu_seq.sv
// rtl/reg_alu_seq.sv - instruction sequencer driving the 16-bit register-file/ALU datapath
//
// Purpose: buffers 16-bit instruction words in a DEPTH-entry FIFO, decodes them
// one per cycle and drives registered control/data into the register-file/ALU
// datapath. Supports ALU ops, two-word LOADI, NOP and a sticky HALT.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   in_valid     upstream word present
//   in_data      instruction or immediate word
//   in_ready     word accepted this cycle (low when full, halted or in reset)
//   sel          1 = write back ALU result, 0 = write back d_in
//   wr           one-cycle register-file write strobe
//   op           ALU operation
//   rd_addr_a    read port A address
//   rd_addr_b    read port B address
//   wr_addr      write address
//   d_in         LOADI immediate
//   halted       HALT has been executed
//   issue_count  number of wr pulses issued (wrapping)
//
// Optional feature (macro CARRY_FLAG_EN): adds input cout and output carry_flag,
// which captures cout on every ALU write-back cycle.
module reg_alu_seq #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        sel,
  output logic        wr,
  output logic [1:0]  op,
  output logic [2:0]  rd_addr_a,
  output logic [2:0]  rd_addr_b,
  output logic [2:0]  wr_addr,
  output logic [15:0] d_in,
  output logic        halted,
`ifdef CARRY_FLAG_EN
  input  logic        cout,
  output logic        carry_flag,
`endif
  output logic [15:0] issue_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  localparam logic [1:0] T_ALU   = 2'b00;
  localparam logic [1:0] T_LOADI = 2'b01;
  localparam logic [1:0] T_NOP   = 2'b10;
  localparam logic [1:0] T_HALT  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_IMM, S_HLT} state_t;

  state_t state, state_nxt;

  // Instruction FIFO
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_full, fifo_empty, push, pop, last_word;
  logic [15:0]   head;
  logic [1:0]    head_type;

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign in_ready   = !fifo_full && !halted && reset;
  assign push       = in_valid && in_ready;
  assign head       = mem[rd_ptr];
  assign head_type  = head[15:14];
  // The word being popped is the last one unless a push refills the FIFO on the same edge.
  assign last_word  = (count == ONE_CNT) && !push;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state and pop
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (fifo_empty) begin
          state_nxt = S_IDLE;
        end else begin
          pop = 1'b1;
          case (head_type)
            T_LOADI: state_nxt = S_IMM;
            T_HALT:  state_nxt = S_HLT;
            default: state_nxt = last_word ? S_IDLE : S_ISSUE;
          endcase
        end
      end
      S_IMM: begin
        // The immediate is the next word taken raw, whatever its type bits say.
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = last_word ? S_IDLE : S_ISSUE;
        end
      end
      S_HLT: begin
        state_nxt = S_HLT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: next values of the registered outputs
  logic        sel_nxt, wr_nxt, halted_nxt;
  logic [1:0]  op_nxt;
  logic [2:0]  rd_a_nxt, rd_b_nxt, wr_addr_nxt, imm_addr, imm_addr_nxt;
  logic [15:0] d_in_nxt;

  always_comb begin
    sel_nxt      = sel;
    wr_nxt       = 1'b0;
    op_nxt       = op;
    rd_a_nxt     = rd_addr_a;
    rd_b_nxt     = rd_addr_b;
    wr_addr_nxt  = wr_addr;
    d_in_nxt     = d_in;
    imm_addr_nxt = imm_addr;
    halted_nxt   = halted;
    case (state)
      S_ISSUE: begin
        if (!fifo_empty) begin
          case (head_type)
            T_ALU: begin
              sel_nxt     = 1'b1;
              wr_nxt      = 1'b1;
              op_nxt      = head[13:12];
              rd_a_nxt    = head[11:9];
              rd_b_nxt    = head[8:6];
              wr_addr_nxt = head[5:3];
            end
            T_LOADI: imm_addr_nxt = head[5:3];
            T_NOP:   ;
            T_HALT:  halted_nxt = 1'b1;
            default: ;
          endcase
        end
      end
      S_IMM: begin
        if (!fifo_empty) begin
          sel_nxt     = 1'b0;
          wr_nxt      = 1'b1;
          d_in_nxt    = head;
          wr_addr_nxt = imm_addr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel         <= 1'b0;
      wr          <= 1'b0;
      op          <= '0;
      rd_addr_a   <= '0;
      rd_addr_b   <= '0;
      wr_addr     <= '0;
      d_in        <= '0;
      imm_addr    <= '0;
      halted      <= 1'b0;
      issue_count <= '0;
    end else begin
      sel         <= sel_nxt;
      wr          <= wr_nxt;
      op          <= op_nxt;
      rd_addr_a   <= rd_a_nxt;
      rd_addr_b   <= rd_b_nxt;
      wr_addr     <= wr_addr_nxt;
      d_in        <= d_in_nxt;
      imm_addr    <= imm_addr_nxt;
      halted      <= halted_nxt;
      issue_count <= issue_count + {15'd0, wr};
    end
  end

`ifdef CARRY_FLAG_EN
  // Only ALU write-backs carry a meaningful cout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          carry_flag <= 1'b0;
    else if (wr && sel)  carry_flag <= cout;
  end
`endif

endmodule

// File: tb/tb_reg_alu_seq.sv
// tb/tb_reg_alu_seq.sv - self-checking bench for reg_alu_seq
module tb_reg_alu_seq;

  localparam int DEPTH = 2;
  localparam int NV    = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready, sel, wr, halted;
  logic [1:0]  op;
  logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic [15:0] d_in, issue_count;
`ifdef CARRY_FLAG_EN
  logic        cout;
  logic        carry_flag;
`endif

  always #5 clk = ~clk;

  reg_alu_seq #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .sel         (sel),
    .wr          (wr),
    .op          (op),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .wr_addr     (wr_addr),
    .d_in        (d_in),
    .halted      (halted),
`ifdef CARRY_FLAG_EN
    .cout        (cout),
    .carry_flag  (carry_flag),
`endif
    .issue_count (issue_count)
  );

  typedef struct {
    logic [15:0] word;
    logic        exp_wr;
    logic        exp_sel;
    logic [1:0]  exp_op;
    logic [2:0]  exp_a;
    logic [2:0]  exp_b;
    logic [2:0]  exp_w;
    logic [15:0] exp_d;
  } vec_t;

  vec_t vec [NV];
  vec_t sb [$];
  vec_t mon_e;

  int n_checks    = 0;
  int n_fail      = 0;
  int wr_pulses   = 0;
  int run_len     = 0;
  int max_run     = 0;
  int exp_issue   = 0;
  int full_stalls = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic void set_vec(input int i, input logic [15:0] w, input logic ew,
                                  input logic es, input logic [1:0] eo, input logic [2:0] ea,
                                  input logic [2:0] eb, input logic [2:0] ewa, input logic [15:0] ed);
    vec[i].word    = w;
    vec[i].exp_wr  = ew;
    vec[i].exp_sel = es;
    vec[i].exp_op  = eo;
    vec[i].exp_a   = ea;
    vec[i].exp_b   = eb;
    vec[i].exp_w   = ewa;
    vec[i].exp_d   = ed;
  endfunction

  // Scoreboard side: every wr pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && wr === 1'b1) begin
      wr_pulses++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (sb.size() == 0) begin
        check("wr_unexpected", 64'(sb.size()), 64'd1);
      end else begin
        mon_e = sb.pop_front();
        check("wr_fields",
              64'({sel, op, rd_addr_a, rd_addr_b, wr_addr, d_in}),
              64'({mon_e.exp_sel, mon_e.exp_op, mon_e.exp_a, mon_e.exp_b, mon_e.exp_w, mon_e.exp_d}));
      end
    end else begin
      run_len = 0;
    end
  end

  // Streams table rows with in_valid held high, advancing on each accepted word.
  task automatic stream(input int first, input int n);
    bit acc;
    @(posedge clk); #1;
    in_valid = 1'b1;
    for (int k = 0; k < n; k++) begin
      in_data = vec[first+k].word;
      acc = 1'b0;
      for (int t = 0; t < 40 && !acc; t++) begin
        @(negedge clk);
        if (in_ready) acc = 1'b1;
        else          full_stalls++;
        @(posedge clk); #1;
      end
      check("push_accept", 64'(acc), 64'd1);
      if (acc && vec[first+k].exp_wr) begin
        sb.push_back(vec[first+k]);
        exp_issue++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check(name, 64'(sb.size()), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_reset(input int cycles);
    @(posedge clk); #2;
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_async_halted", 64'(halted), 64'd0);
    check("rst_async_ready", 64'(in_ready), 64'd0);
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    exp_issue = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h0350;
`ifdef CARRY_FLAG_EN
    cout = 1'b0;
`endif
    //           word     wr sel op a  b  w  d
    set_vec(0,  16'h0350, 1, 1, 0, 1, 5, 2, 16'h0000);
    set_vec(1,  16'h4018, 0, 0, 0, 0, 0, 0, 16'h0000);
    set_vec(2,  16'hCDEF, 1, 0, 0, 1, 5, 3, 16'hCDEF);
    set_vec(3,  16'h2735, 1, 1, 2, 3, 4, 6, 16'hCDEF);
    set_vec(4,  16'h31C8, 1, 1, 3, 0, 7, 1, 16'hCDEF);
    set_vec(5,  16'h1C87, 1, 1, 1, 6, 2, 0, 16'hCDEF);
    set_vec(6,  16'h0B68, 1, 1, 0, 5, 5, 5, 16'hCDEF);
    set_vec(7,  16'h8000, 0, 0, 0, 0, 0, 0, 16'h0000);
    set_vec(8,  16'h4028, 0, 0, 0, 0, 0, 0, 16'h0000);
    set_vec(9,  16'hFFFF, 1, 0, 0, 5, 5, 5, 16'hFFFF);
    set_vec(10, 16'h8123, 0, 0, 0, 0, 0, 0, 16'h0000);
    set_vec(11, 16'h0350, 1, 1, 0, 1, 5, 2, 16'hFFFF);
    set_vec(12, 16'h8000, 0, 0, 0, 0, 0, 0, 16'h0000);
    set_vec(13, 16'hC000, 0, 0, 0, 0, 0, 0, 16'h0000);
    set_vec(14, 16'h0350, 0, 0, 0, 0, 0, 0, 16'h0000);
    set_vec(15, 16'h4020, 0, 0, 0, 0, 0, 0, 16'h0000);
    set_vec(16, 16'h2735, 1, 1, 2, 3, 4, 6, 16'h0000);
    set_vec(17, 16'h0350, 1, 1, 0, 1, 5, 2, 16'h0000);
    set_vec(18, 16'h4018, 0, 0, 0, 0, 0, 0, 16'h0000);
    set_vec(19, 16'h00AA, 1, 0, 0, 1, 5, 3, 16'h00AA);

    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("rst_ready", 64'(in_ready), 64'd0);
      check("rst_wr", 64'(wr), 64'd0);
    end
    check("rst_outputs",
          64'({in_ready, sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in, halted, issue_count}),
          64'd0);
    @(posedge clk); #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(in_ready), 64'd1);

    stream(0, 1);
    drain("alu_drain");
    check("alu_count", 64'(issue_count), 64'(exp_issue));

    stream(1, 1);
    p = wr_pulses;
    repeat (3) @(negedge clk);
    check("imm_stall_no_wr", 64'(wr_pulses), 64'(p));
    stream(2, 1);
    drain("imm_drain");
    check("imm_count", 64'(issue_count), 64'(exp_issue));

    max_run     = 0;
    full_stalls = 0;
    stream(3, DEPTH + 2);
    drain("full_drain");
    check("full_stalled", 64'(full_stalls > 0), 64'd1);
    check("full_run", 64'(max_run), 64'(DEPTH + 2));
    check("full_count", 64'(issue_count), 64'(exp_issue));

    stream(7, 5);
    drain("mix_drain");
    check("mix_count", 64'(issue_count), 64'(exp_issue));

    p = wr_pulses;
    stream(12, 3);
    repeat (8) @(negedge clk);
    check("halt_flag", 64'(halted), 64'd1);
    check("halt_ready", 64'(in_ready), 64'd0);
    check("halt_no_wr", 64'(wr_pulses), 64'(p));
    check("halt_count", 64'(issue_count), 64'(exp_issue));
    pulse_reset(2);
    @(negedge clk);
    check("halt_cleared", 64'(halted), 64'd0);
    check("halt_ready_back", 64'(in_ready), 64'd1);

    stream(15, 1);
    repeat (3) @(negedge clk);
    pulse_reset(2);
    @(negedge clk);
    check("imm_rst_count", 64'(issue_count), 64'd0);
    stream(16, 1);
    drain("imm_rst_drain");
    check("imm_rst_count2", 64'(issue_count), 64'(exp_issue));

    pulse_reset(1);
    @(negedge clk);
`ifdef CARRY_FLAG_EN
    check("carry_rst", 64'(carry_flag), 64'd0);
    cout = 1'b1;
`endif
    stream(17, 1);
    drain("carry_alu_drain");
`ifdef CARRY_FLAG_EN
    cout = 1'b0;
    check("carry_set", 64'(carry_flag), 64'd1);
`endif
    stream(18, 2);
    drain("carry_imm_drain");
`ifdef CARRY_FLAG_EN
    check("carry_hold", 64'(carry_flag), 64'd1);
`endif
    check("carry_count", 64'(issue_count), 64'(exp_issue));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_alu_seq.md
Name: reg_alu_seq

Overview:
- Upstream instruction sequencer for the 16-bit register-file/ALU datapath.
- Accepts 16-bit instruction words over a valid/ready handshake and buffers them in a small FIFO.
- Decodes each word and drives the datapath control and data inputs: sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in.
- Handles two-word load-immediate instructions, NOPs and a sticky HALT.

Parameters:
DEPTH, 4, instruction FIFO entries; power of two, at least 2.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset; low clears all state immediately.
in_valid  input  1  upstream presents an instruction word.
in_data  input  16  instruction or immediate word.
in_ready  output  1  block accepts in_data this cycle.
sel  output  1  1 = write-back from ALU result; 0 = write-back from d_in.
wr  output  1  register-file write strobe; one-cycle pulse per issued write.
op  output  2  ALU operation.
rd_addr_a  output  3  read port A address.
rd_addr_b  output  3  read port B address.
wr_addr  output  3  write address.
d_in  output  16  immediate data for LOADI.
halted  output  1  sequencer has executed HALT.
issue_count  output  16  number of wr pulses issued; wraps 16'hFFFF to 0.

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty; FSM in IDLE; all registered outputs = 0; issue_count = 0; halted = 0; in_ready = 0 while reset is low.
- Handshake:
  - in_ready = !fifo_full && !halted && reset.
  - A word is pushed on any rising edge where in_valid && in_ready.
  - No push when full, even if a pop occurs on the same edge.
  - Push and pop on the same edge are allowed when not full; occupancy stays unchanged.
- Word format:
  - [15:14] type: 00 ALU, 01 LOADI, 10 NOP, 11 HALT.
  - ALU fields: [13:12] op, [11:9] rd_a, [8:6] rd_b, [5:3] wr_addr; [2:0] ignored.
  - LOADI: [5:3] wr_addr; the immediate is the next FIFO word, taken raw regardless of its type bits.
- FSM states:
  - IDLE: FIFO empty; wr=0; go to ISSUE when FIFO is non-empty.
  - ISSUE: pop one word per cycle and decode it.
    - ALU: next cycle drive sel=1, wr=1, op, rd_addr_a, rd_addr_b, wr_addr.
    - LOADI: go to IMM.
    - NOP: wr=0.
    - HALT: go to HLT.
    - After ALU/NOP, go to IDLE if the FIFO has become empty.
  - IMM: wait (wr=0) while the FIFO is empty. On pop, next cycle drive sel=0, wr=1, d_in=word, wr_addr=latched. Then return to ISSUE, or to IDLE if the FIFO is empty.
  - HLT: wr=0; halted=1; in_ready=0; buffered words retained but never issued; exit only via reset.
- Output rules:
  - All outputs are registered. Control for a popped word appears in the cycle after the pop edge; the datapath write lands on the following edge.
  - wr is 0 in every cycle without an issued write.
  - sel, op, addresses and d_in hold their last values when wr=0.
  - issue_count increments on each cycle where wr=1.
- Throughput: back-to-back ALU words issue at 1 per cycle. A LOADI takes 2 pops and produces 1 write.
- Reset mid-operation (for example in IMM, or while the FIFO is partly full) discards all buffered words and the pending LOADI.

Optional Feature:
- Macro: CARRY_FLAG_EN.
- Defined:
  - Adds input cout (1 bit, from the ALU) and output carry_flag (1 bit, reset 0).
  - carry_flag captures cout on each clock edge where wr=1 and sel=1 (ALU write-back).
  - carry_flag holds its value on LOADI, NOP and idle cycles.
- Not defined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Reset held low 12 cycles with in_valid=1 -> in_ready=0, wr=0, all outputs 0. After release, in_ready=1.
- Push 16'h0350 (ALU op=00 a=1 b=5 w=2) -> exactly one wr=1 cycle with sel=1, op=00, rd_addr_a=1, rd_addr_b=5, wr_addr=2; issue_count=1.
- Push 16'h4018, stall 3 cycles, then push 16'hCDEF -> no wr during the stall. Then one wr=1 cycle with sel=0, wr_addr=3, d_in=16'hCDEF.
- Push DEPTH+2 ALU words with in_valid held high -> in_ready deasserts at full with no word lost. DEPTH+2 consecutive wr pulses, in order.
- Push 16'h8000, 16'hC000, 16'h0350 -> no wr; halted=1 and in_ready=0 from the cycle after HALT decode; the ALU word is never issued. Asserting reset clears halted.
- With CARRY_FLAG_EN, tie cout=1 during the ALU issue of 16'h0350, then run a LOADI -> carry_flag=1 and stays 1 through the LOADI write.
